// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts an N-bit word over valid/ready and shifts it out
// LSB first on serial_out, one bit per clk. Back-to-back words stream with no gap.
// Optional feature macro: PARITY_EN appends one even-parity bit to every frame
// (frame length N+1). Without it frames are exactly N bits long.
module parallel_to_serial #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         serial_out,
  output logic         busy,
  output logic         frame_tick
);

`ifdef PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state;
  logic [L-1:0]   shift_reg;
  logic [CNT_W-1:0] count;
  logic           last;
  logic           accept;
  logic [L-1:0]   load_word;

  // Parity (when enabled) rides in the top bit of the shift register so it
  // falls out naturally on the cycle after bit N-1.
`ifdef PARITY_EN
  assign load_word = {^data_in, data_in};
`else
  assign load_word = data_in;
`endif

  // Handshake and status outputs are decoded purely from registered state.
  assign last       = (state == SHIFT) && (count == LAST);
  assign in_ready   = (state == IDLE) || last;
  assign accept     = in_valid && in_ready;
  assign busy       = (state == SHIFT);
  assign frame_tick = last;
  assign serial_out = busy & shift_reg[0];

  // Frame sequencer: load on accept, shift right with zero fill, reload on the
  // last bit when a new word is offered so frames stay contiguous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= load_word;
            count     <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            shift_reg <= load_word;
            count     <= '0;
          end else if (last) begin
            shift_reg <= '0;
            count     <= '0;
            state     <= IDLE;
          end else begin
            shift_reg <= shift_reg >> 1;
            count     <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial. The reference model is a queue
// of bits still to be transmitted: the head is what serial_out must show, and
// a word may be accepted when at most one bit remains.
module tb_parallel_to_serial;

  localparam int N = 8;
`ifdef PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] data_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         serial_out;
  logic         busy;
  logic         frame_tick;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int ticks_seen;

  parallel_to_serial #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, drive inputs, advance model.
  task automatic cycle(input logic v, input logic [N-1:0] d, output bit acc);
    int  sz;
    bit  par;
    @(negedge clk);
    sz = exp_q.size();
    check("serial_out", serial_out, (sz > 0) ? exp_q[0] : 1'b0);
    check("busy",       busy,       sz > 0);
    check("in_ready",   in_ready,   sz <= 1);
    check("frame_tick", frame_tick, sz == 1);
    if (frame_tick) ticks_seen++;
    in_valid = v;
    data_in  = d;
    acc = v && (sz <= 1);
    if (sz > 0) void'(exp_q.pop_front());
    if (acc) begin
      par = 1'b0;
      for (int k = 0; k < N; k++) begin
        exp_q.push_back(d[k]);
        par ^= d[k];
      end
      if (L > N) exp_q.push_back(par);
    end
  endtask

  // Offer a word with in_valid held high until the model accepts it.
  task automatic send(input logic [N-1:0] w);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 4 * L) begin
      cycle(1'b1, w, acc);
      guard++;
    end
    if (!acc) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n, input bit scramble);
    bit acc;
    for (int i = 0; i < n; i++)
      cycle(1'b0, scramble ? N'($urandom) : '0, acc);
  endtask

  initial begin
    bit acc;

    // reset held, then released with in_valid low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_serial_out", serial_out, 0);
    check("rst_busy",       busy,       0);
    check("rst_frame_tick", frame_tick, 0);
    reset = 1'b0;
    idle(20, 1'b0);

    // single word 8'hA5, explicit bit pattern also checked by the model
    ticks_seen = 0;
    send(8'hA5);
    idle(L + 3, 1'b1);
    check("a5_ticks", ticks_seen, 1);

    // back-to-back stream, no gap expected
    ticks_seen = 0;
    send(8'h01);
    send(8'hFF);
    send(8'h80);
    idle(L + 3, 1'b1);
    check("stream_ticks", ticks_seen, 3);

    // parity-relevant back-to-back pair
    ticks_seen = 0;
    send(8'h07);
    send(8'h03);
    idle(L + 3, 1'b0);
    check("pair_ticks", ticks_seen, 2);

    // reset mid-frame after the 3rd bit of 8'hFF
    send(8'hFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, N'($urandom), acc);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_serial_out", serial_out, 0);
    check("midrst_busy",       busy,       0);
    check("midrst_frame_tick", frame_tick, 0);
    check("midrst_in_ready",   in_ready,   1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(8'h3C);
    idle(L + 2, 1'b1);

    // randomized valid and data, data scrambled every cycle
    ticks_seen = 0;
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), N'($urandom), acc);
    idle(L + 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
